// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR sequencer.
// Holds the FSM state encodings, the seed width, the step counter width
// and the fallback seed used when a zero seed is requested.
package lfsr_pkg;

    localparam int unsigned SEED_W     = 8;
    localparam int unsigned STEP_CNT_W = 16;

    localparam logic [SEED_W-1:0] SEED_DEFAULT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_PAUSE = 2'b11
    } state_e;

endpackage

// File: rtl/lfsr_sched_tick_gen.sv
// tick_gen: free-running divider that paces automatic LFSR steps in RUN.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the counter (wins over en)
//   en         : count enable
//   tick       : combinational, high while enabled and the counter sits at CLK_NUM-1
module tick_gen #(
    parameter int unsigned CLK_NUM = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned TICK_W = (CLK_NUM > 1) ? $clog2(CLK_NUM) : 1;
    localparam logic [TICK_W-1:0] LAST = TICK_W'(CLK_NUM - 1);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    // Count 0..CLK_NUM-1 and wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/lfsr_sched.sv
// lfsr_sched: sequencer for an external 8-bit LFSR.
// Seeds the LFSR, steps it on demand (PAUSE) or periodically (RUN), counts
// steps and flags when the LFSR returns to the seed, auto-stopping RUN.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start, stop, step, load     : requests, priority load > stop > start > step
//   seed                        : requested seed (zero maps to SEED_DEFAULT)
//   lfsr_q                      : current external LFSR value
//   lfsr_load, lfsr_seed        : one-cycle seed load to the LFSR
//   lfsr_en                     : one-cycle LFSR shift enable
//   state, busy                 : FSM state, high in RUN
//   step_cnt                    : saturating count of lfsr_en pulses since LOAD
//   period_done                 : sticky, LFSR came back to the seed
module lfsr_sched #(
    parameter int unsigned                    CLK_NUM      = 5000000,
    parameter logic [lfsr_pkg::SEED_W-1:0]    SEED_DEFAULT = lfsr_pkg::SEED_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              step,
    input  logic                              load,
    input  logic [lfsr_pkg::SEED_W-1:0]       seed,
    input  logic [lfsr_pkg::SEED_W-1:0]       lfsr_q,
    output logic                              lfsr_load,
    output logic [lfsr_pkg::SEED_W-1:0]       lfsr_seed,
    output logic                              lfsr_en,
    output logic [1:0]                        state,
    output logic                              busy,
    output logic [lfsr_pkg::STEP_CNT_W-1:0]   step_cnt,
    output logic                              period_done
);

    import lfsr_pkg::*;

    state_e                  state_q, state_d;
    logic                    lfsr_load_q, lfsr_load_d;
    logic                    lfsr_en_q, lfsr_en_d;
    logic                    busy_q, busy_d;
    logic                    period_done_q, period_done_d;
    logic                    step_prev_q, step_prev_d;
    logic                    chk_q, chk_d;
    logic [SEED_W-1:0]       lfsr_seed_q, lfsr_seed_d;
    logic [SEED_W-1:0]       seed_reg_q, seed_reg_d;
    logic [STEP_CNT_W-1:0]   step_cnt_q, step_cnt_d;

    logic                    tick;
    logic                    tick_en;
    logic                    tick_clr;
    logic                    step_rise;
    logic                    match;
    logic                    load_entry;
    logic [SEED_W-1:0]       seed_eff;

    // Tick counter only runs in RUN; held at zero elsewhere so RUN entry starts fresh.
    assign tick_en  = (state_q == ST_RUN);
    assign tick_clr = !tick_en;

    tick_gen #(
        .CLK_NUM (CLK_NUM)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        lfsr_en_d     = 1'b0;
        lfsr_seed_d   = lfsr_seed_q;
        seed_reg_d    = seed_reg_q;
        step_cnt_d    = step_cnt_q;
        period_done_d = period_done_q;
        step_prev_d   = step;

        step_rise = step && !step_prev_q;
        seed_eff  = (seed == '0) ? SEED_DEFAULT : seed;
        // chk_q marks the cycle in which lfsr_q reflects the latest shift.
        match     = chk_q && (lfsr_q == seed_reg_q)
                    && ((state_q == ST_RUN) || (state_q == ST_PAUSE));

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_PAUSE;
            end
            ST_RUN: begin
                if (load) begin
                    state_d = ST_LOAD;
                end else if (stop || match) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    lfsr_en_d = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (load) begin
                    state_d = ST_LOAD;
                end else if (!stop) begin
                    if (start) begin
                        state_d = ST_RUN;
                    end else if (step_rise) begin
                        lfsr_en_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        load_entry = (state_d == ST_LOAD);

        if (load_entry) begin
            lfsr_seed_d   = seed_eff;
            seed_reg_d    = seed_eff;
            step_cnt_d    = '0;
            period_done_d = 1'b0;
        end else begin
            if (match) begin
                period_done_d = 1'b1;
            end
            if (lfsr_en_d && (step_cnt_q != '1)) begin
                step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
            end
        end

        // A shift issued just before a LOAD must not be compared with the new seed.
        chk_d       = lfsr_en_q && !load_entry;
        lfsr_load_d = load_entry;
        busy_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            lfsr_load_q   <= 1'b0;
            lfsr_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            period_done_q <= 1'b0;
            step_prev_q   <= 1'b0;
            chk_q         <= 1'b0;
            lfsr_seed_q   <= SEED_DEFAULT;
            seed_reg_q    <= SEED_DEFAULT;
            step_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_load_q   <= lfsr_load_d;
            lfsr_en_q     <= lfsr_en_d;
            busy_q        <= busy_d;
            period_done_q <= period_done_d;
            step_prev_q   <= step_prev_d;
            chk_q         <= chk_d;
            lfsr_seed_q   <= lfsr_seed_d;
            seed_reg_q    <= seed_reg_d;
            step_cnt_q    <= step_cnt_d;
        end
    end

    assign state       = state_q;
    assign lfsr_load   = lfsr_load_q;
    assign lfsr_seed   = lfsr_seed_q;
    assign lfsr_en     = lfsr_en_q;
    assign busy        = busy_q;
    assign step_cnt    = step_cnt_q;
    assign period_done = period_done_q;

endmodule

// File: tb/tb_lfsr_sched.sv
// tb_lfsr_sched: directed bench for lfsr_sched with CLK_NUM=4.
// Expected lfsr_load / lfsr_en pulses are queued by the stimulus and checked
// by a monitor whenever the DUT raises either pulse.
module tb_lfsr_sched;

    localparam int unsigned CLK_NUM = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        step  = 1'b0;
    logic        load  = 1'b0;
    logic [7:0]  seed  = 8'h00;
    logic [7:0]  lfsr  = 8'h00;
    logic        lfsr_load;
    logic [7:0]  lfsr_seed;
    logic        lfsr_en;
    logic [1:0]  state;
    logic        busy;
    logic [15:0] step_cnt;
    logic        period_done;

    typedef struct packed {
        logic        is_load;
        logic [31:0] cyc;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   pushed = 0;

    lfsr_sched #(
        .CLK_NUM      (CLK_NUM),
        .SEED_DEFAULT (8'h01)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .load        (load),
        .seed        (seed),
        .lfsr_q      (lfsr),
        .lfsr_load   (lfsr_load),
        .lfsr_seed   (lfsr_seed),
        .lfsr_en     (lfsr_en),
        .state       (state),
        .busy        (busy),
        .step_cnt    (step_cnt),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
    endfunction

    // External LFSR driven by the sequencer.
    always @(posedge clk) begin
        if (lfsr_load)     lfsr <= lfsr_seed;
        else if (lfsr_en)  lfsr <= lfsr_next(lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_load(input int c, input logic [7:0] s);
        exp_q.push_back('{1'b1, 32'(c), 16'(s)});
        pushed++;
    endtask

    task automatic exp_en(input int c, input int n);
        exp_q.push_back('{1'b0, 32'(c), 16'(n)});
        pushed++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (lfsr_load || lfsr_en) begin
                pulses++;
                check("load_en_exclusive", 32'(lfsr_load & lfsr_en), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: load=%0b en=%0b cycle=%0d expected no pulse",
                             lfsr_load, lfsr_en, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_load", 32'(lfsr_load), 32'(e.is_load));
                    check("pulse_cycle", 32'(cyc), e.cyc);
                    if (e.is_load) check("pulse_lfsr_seed", 32'(lfsr_seed), 32'(e.val));
                    else           check("pulse_step_cnt", 32'(step_cnt), 32'(e.val));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int period;
        int entry;
        logic [7:0] v;

        fork
            monitor();
        join_none

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_state",       32'(state),       32'd0);
        check("rst_lfsr_load",   32'(lfsr_load),   32'd0);
        check("rst_lfsr_en",     32'(lfsr_en),     32'd0);
        check("rst_lfsr_seed",   32'(lfsr_seed),   32'h01);
        check("rst_step_cnt",    32'(step_cnt),    32'd0);
        check("rst_period_done", 32'(period_done), 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(1);

        // Zero seed maps to the default seed.
        seed = 8'h00;
        load = 1'b1;
        exp_load(cyc + 1, 8'h01);
        wait_cyc(1);
        load = 1'b0;
        check("load_state", 32'(state), 32'd1);
        wait_cyc(1);
        check("load_then_pause", 32'(state), 32'd3);
        check("load_step_cnt", 32'(step_cnt), 32'd0);
        check("load_lfsr", 32'(lfsr), 32'h01);

        // Single-cycle step.
        step = 1'b1;
        exp_en(cyc + 1, 1);
        wait_cyc(1);
        step = 1'b0;
        wait_cyc(1);
        check("step_lfsr", 32'(lfsr), 32'h80);
        check("step_cnt_1", 32'(step_cnt), 32'd1);
        check("step_state", 32'(state), 32'd3);

        // Held step gives one pulse.
        step = 1'b1;
        exp_en(cyc + 1, 2);
        wait_cyc(4);
        step = 1'b0;
        wait_cyc(2);
        check("held_step_lfsr", 32'(lfsr), 32'h40);
        check("held_step_cnt", 32'(step_cnt), 32'd2);

        // RUN: pulses 4 cycles apart; stop lands on a tick cycle.
        start = 1'b1;
        exp_en(cyc + 5, 3);
        exp_en(cyc + 9, 4);
        wait_cyc(1);
        start = 1'b0;
        check("run_state", 32'(state), 32'd2);
        check("run_busy", 32'(busy), 32'd1);
        wait_cyc(11);
        stop = 1'b1;
        wait_cyc(1);
        stop = 1'b0;
        check("stop_state", 32'(state), 32'd3);
        check("stop_busy", 32'(busy), 32'd0);
        wait_cyc(10);
        check("stop_lfsr", 32'(lfsr), 32'h10);
        check("stop_step_cnt", 32'(step_cnt), 32'd4);

        // load + stop + start together in RUN: LOAD wins.
        seed  = 8'h5A;
        start = 1'b1;
        exp_en(cyc + 5, 5);
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(5);
        load  = 1'b1;
        stop  = 1'b1;
        start = 1'b1;
        exp_load(cyc + 1, 8'h5A);
        wait_cyc(1);
        load  = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        check("prio_state_load", 32'(state), 32'd1);
        check("prio_step_cnt", 32'(step_cnt), 32'd0);
        wait_cyc(1);
        check("prio_state_pause", 32'(state), 32'd3);
        check("prio_lfsr", 32'(lfsr), 32'h5A);

        // Full period from seed 01 with auto-stop.
        v = 8'h01;
        period = 0;
        do begin
            v = lfsr_next(v);
            period++;
        end while (v != 8'h01 && period < 1000);
        seed = 8'h01;
        load = 1'b1;
        exp_load(cyc + 1, 8'h01);
        wait_cyc(1);
        load = 1'b0;
        wait_cyc(1);
        start = 1'b1;
        entry = cyc + 1;
        for (int k = 1; k <= period; k++) exp_en(entry + 4 * k, k);
        wait_cyc(1);
        start = 1'b0;
        for (int i = 0; i < 1500 && !period_done; i++) wait_cyc(1);
        check("period_done", 32'(period_done), 32'd1);
        check("period_done_cycle", 32'(cyc), 32'(entry + 4 * period + 2));
        check("period_state", 32'(state), 32'd3);
        check("period_step_cnt", 32'(step_cnt), 32'(period));
        check("period_lfsr", 32'(lfsr), 32'h01);
        wait_cyc(8);
        check("period_sticky", 32'(period_done), 32'd1);

        // Reset between clock edges mid-RUN with a tick pending.
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_lfsr_en", 32'(lfsr_en), 32'd0);
        check("midrst_lfsr_load", 32'(lfsr_load), 32'd0);
        check("midrst_step_cnt", 32'(step_cnt), 32'd0);
        check("midrst_period_done", 32'(period_done), 32'd0);
        check("midrst_lfsr_seed", 32'(lfsr_seed), 32'h01);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(1);
        start = 1'b1;
        step  = 1'b1;
        wait_cyc(3);
        start = 1'b0;
        step  = 1'b0;
        check("idle_ignores_start", 32'(state), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        wait_cyc(8);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("pulse_count", 32'(pulses), 32'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
